// File: rtl/combinational_adder.sv
`default_nettype none
// ============================================================================
// Module      : combinational_adder
// Description : 16-bit unsigned adder, z = (x + y) mod 2^16, built as a
//               two-level carry-lookahead structure (four 4-bit CLA groups
//               plus a group lookahead unit). Clock and reset are present
//               only for port-shell uniformity and drive no logic.
// Revision    : 1.0 - initial release
// ============================================================================
module combinational_adder (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] io_x,
   input  logic [15:0] io_y,
   output logic [15:0] io_z
);

   localparam logic c_cin0 = 1'b0;

   logic [15:0] w_g;        // per-bit generate
   logic [15:0] w_p;        // per-bit propagate
   logic [15:0] w_sum;
   logic [3:0]  w_grp_g;    // group generate
   logic [3:0]  w_grp_p;    // group propagate
   logic [3:0]  w_grp_c;    // carry into each group
   logic        w_c16;      // final carry-out, discarded (wrap-around)

   // Bit-level generate/propagate
   assign w_g = io_x & io_y;
   assign w_p = io_x ^ io_y;

   // Group lookahead: carries into groups 1..3 from group G/P, no ripple
   assign w_grp_c[0] = c_cin0;
   assign w_grp_c[1] = w_grp_g[0];
   assign w_grp_c[2] = w_grp_g[1]
                     | (w_grp_p[1] & w_grp_g[0]);
   assign w_grp_c[3] = w_grp_g[2]
                     | (w_grp_p[2] & w_grp_g[1])
                     | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0]);
   assign w_c16      = w_grp_g[3] | (w_grp_p[3] & w_grp_c[3]);

   // Four 4-bit CLA groups with flattened sum-of-products carries
   generate
      for (genvar k = 0; k < 4; k++) begin : g_group
         logic [3:0] w_gb;
         logic [3:0] w_pb;
         logic [3:0] w_c;
         logic       w_cin;

         assign w_gb  = w_g[4*k +: 4];
         assign w_pb  = w_p[4*k +: 4];
         assign w_cin = w_grp_c[k];

         assign w_c[0] = w_cin;
         assign w_c[1] = w_gb[0]
                       | (w_pb[0] & w_cin);
         assign w_c[2] = w_gb[1]
                       | (w_pb[1] & w_gb[0])
                       | (w_pb[1] & w_pb[0] & w_cin);
         assign w_c[3] = w_gb[2]
                       | (w_pb[2] & w_gb[1])
                       | (w_pb[2] & w_pb[1] & w_gb[0])
                       | (w_pb[2] & w_pb[1] & w_pb[0] & w_cin);

         assign w_grp_g[k] = w_gb[3]
                           | (w_pb[3] & w_gb[2])
                           | (w_pb[3] & w_pb[2] & w_gb[1])
                           | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);
         assign w_grp_p[k] = &w_pb;

         assign w_sum[4*k +: 4] = w_pb ^ w_c;
      end
   endgenerate

   assign io_z = w_sum;

   // Clock, reset and the final carry intentionally go nowhere
   logic w_unused;
   assign w_unused = &{clock, reset, w_c16};

endmodule
`default_nettype wire

// File: tb/tb_combinational_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_combinational_adder
// Description : Directed and random self-checking bench for the 16-bit CLA
//               adder. Inputs are poked and the output checked without
//               waiting for a clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_combinational_adder;

   logic        clock;
   logic        reset;
   logic [15:0] io_x;
   logic [15:0] io_y;
   logic [15:0] io_z;

   int total;
   int bad;

   combinational_adder dut (
      .clock (clock),
      .reset (reset),
      .io_x  (io_x),
      .io_y  (io_y),
      .io_z  (io_z)
   );

   // Free-running clock, irrelevant to the datapath
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset;
      reset = 1'b0;
      io_x  = 16'h0000;
      io_y  = 16'h0000;
      #1;
      total++;
      if (io_z !== 16'h0000) begin
         bad++;
         $display("FAIL reset_zero: got %h expected %h", io_z, 16'h0000);
      end
      #3 reset = 1'b1;
      #1;
      total++;
      if (io_z !== 16'h0000) begin
         bad++;
         $display("FAIL reset_release_zero: got %h expected %h", io_z, 16'h0000);
      end
   endtask

   task automatic test_vectors(input string name,
                               input logic [15:0] a [],
                               input logic [15:0] b [],
                               input logic [15:0] e []);
      for (int i = 0; i < a.size(); i++) begin
         io_x = a[i];
         io_y = b[i];
         #1;
         total++;
         if (io_z !== e[i]) begin
            bad++;
            $display("FAIL %s[%0d]: %h+%h got %h expected %h",
                     name, i, a[i], b[i], io_z, e[i]);
         end
      end
   endtask

   task automatic test_basic;
      test_vectors("basic", '{16'h0001, 16'h1234},
                            '{16'h0002, 16'h4321},
                            '{16'h0003, 16'h5555});
   endtask

   task automatic test_wrap;
      test_vectors("wrap", '{16'hFFFF, 16'h7FFF, 16'h0FFF, 16'hFFFF},
                           '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF},
                           '{16'h0000, 16'h8000, 16'h1000, 16'hFFFE});
   endtask

   task automatic test_group_boundary;
      test_vectors("group", '{16'h000F, 16'h00FF, 16'h8000, 16'h0001},
                            '{16'h0001, 16'h0001, 16'h8000, 16'hFFFF},
                            '{16'h0010, 16'h0100, 16'h0000, 16'h0000});
   endtask

   task automatic test_identity;
      test_vectors("identity", '{16'h0000, 16'h5A5A, 16'hFFFF},
                               '{16'h0000, 16'h0000, 16'h0000},
                               '{16'h0000, 16'h5A5A, 16'hFFFF});
   endtask

   task automatic check_hold(input string name);
      total++;
      if (io_z !== 16'h00FF) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, io_z, 16'h00FF);
      end
   endtask

   task automatic test_reset_independence;
      io_x = 16'h00AA;
      io_y = 16'h0055;
      #1 check_hold("rst_hold_pre");
      @(posedge clock);
      #2 reset = 1'b0;
      #1 check_hold("rst_hold_asserted");
      @(posedge clock);
      #1 check_hold("rst_hold_edge_in_reset");
      #2 reset = 1'b1;
      #1 check_hold("rst_hold_released");
      @(negedge clock);
      #1 check_hold("rst_hold_after");
   endtask

   task automatic test_random;
      logic [15:0] a, b, e;
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         e = 16'((32'(a) + 32'(b)) & 32'hFFFF);
         io_x = a;
         io_y = b;
         #1;
         total++;
         if (io_z !== e) begin
            bad++;
            $display("FAIL random[%0d]: %h+%h got %h expected %h", i, a, b, io_z, e);
         end
      end
   endtask

   task automatic test_commutativity;
      logic [15:0] a, b, z1;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         io_x = a;
         io_y = b;
         #1 z1 = io_z;
         io_x = b;
         io_y = a;
         #1;
         total++;
         if (io_z !== z1 || io_z !== 16'(a + b)) begin
            bad++;
            $display("FAIL commute[%0d]: %h,%h got %h/%h expected %h",
                     i, a, b, z1, io_z, 16'(a + b));
         end
      end
   endtask

   // Sequence all scenarios, then summarise
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_group_boundary();
      test_identity();
      test_reset_independence();
      test_random();
      test_commutativity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
